csr_arb: RTL and testbench
==========================

Name: csr_arb

Overview:
- Shares one CSR slave channel among NUM_REQ CSR masters. Uses round-robin arbitration with one transaction outstanding at a time.
- Each master-side and slave-side port group obeys the standard CSR valid/ready contract: accept on valid&&ready, hold payload stable under backpressure, response may arrive in the same cycle as request acceptance or later.
- Adds a response timeout that synthesizes a fault response, so a dead CSR target cannot hang the control plane.
- Sits between the core/debug/DMA CSR masters and the CSR decode fabric.

Parameters:
- NUM_REQ, 3, number of masters (>=1).
- ADDR_W, 32, CSR address width.
- DATA_W, 32, CSR data width (multiple of 8).
- PRIV_W, 2, privilege field width.
- TIMEOUT_CYC, 64, cycles in WAIT before a fault is synthesized; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m_req_valid  in  NUM_REQ  per-master request valid.
- m_req_ready  out  NUM_REQ  per-master request ready.
- m_req_write  in  NUM_REQ  write flag.
- m_req_addr  in  NUM_REQ*ADDR_W  packed; master i at [i*ADDR_W +: ADDR_W].
- m_req_wdata  in  NUM_REQ*DATA_W  packed write data.
- m_req_wstrb  in  NUM_REQ*DATA_W/8  packed byte strobes.
- m_req_priv  in  NUM_REQ*PRIV_W  packed privilege.
- m_rsp_valid  out  NUM_REQ  one-hot response valid.
- m_rsp_ready  in  NUM_REQ  per-master response ready.
- m_rsp_rdata  out  DATA_W  shared response data.
- m_rsp_fault  out  1  shared fault flag.
- m_rsp_side_effect  out  1  shared side-effect flag.
- s_req_valid/s_req_write/s_req_addr/s_req_wdata/s_req_wstrb/s_req_priv  out  1/1/ADDR_W/DATA_W/DATA_W/8/PRIV_W  slave request.
- s_req_ready  in  1  slave request ready.
- s_rsp_valid/s_rsp_rdata/s_rsp_fault/s_rsp_side_effect  in  1/DATA_W/1/1  slave response.
- s_rsp_ready  out  1  slave response ready.
- busy  out  1  state != IDLE.
- grant_id  out  IDX_W  registered granted master; IDX_W = $clog2(max(NUM_REQ,2)).
- timeout_pulse  out  1  one-cycle pulse when a fault is synthesized.
- stale_drop_pulse  out  1  one-cycle pulse when an unsolicited slave response is discarded.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0.
  - All valid/ready outputs 0, both pulses 0.
  - Data outputs are don't-care; drive them 0.
- IDLE:
  - All m_req_ready=0, s_req_valid=0.
  - If any m_req_valid is set, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Register grant_id=winner and move to ISSUE.
  - Grant-to-slave latency: 1 cycle after the request is first seen.
- ISSUE:
  - The slave request is a combinational mux of master grant_id: s_req_valid = m_req_valid[g].
  - m_req_ready[g] = s_req_ready; other m_req_ready are 0.
  - If m_req_valid[g] drops before acceptance (a contract violation), return to IDLE and leave rr_ptr unchanged.
  - On s_req_valid && s_req_ready:
    - If s_rsp_valid is high in the same cycle, route it (see response routing). Handshake completes → IDLE, rr_ptr = g+1 mod N. Handshake pending → WAIT.
    - Otherwise → WAIT and clear the counter.
- Response routing (ISSUE acceptance cycle and WAIT):
  - m_rsp_valid[g] = s_rsp_valid; shared rsp data/fault/side_effect come from the slave.
  - s_rsp_ready = m_rsp_ready[g].
- WAIT:
  - Counter increments each cycle s_rsp_valid=0.
  - On response handshake → IDLE, rr_ptr = g+1 mod N.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with no s_rsp_valid → FAULT.
  - A slave response present in the terminal cycle takes precedence over the timeout.
- FAULT:
  - m_rsp_valid[g]=1, rdata=0, fault=1, side_effect=0, s_rsp_ready=0.
  - timeout_pulse=1 on entry cycle only.
  - Held stable until m_rsp_ready[g], then → IDLE with rr_ptr = g+1.
- Stale responses:
  - Any s_rsp_valid while in IDLE, or in ISSUE before request acceptance, is consumed (s_rsp_ready=1) and dropped, with stale_drop_pulse=1.
  - Slaves must not return a timed-out response in the exact cycle a new request is accepted; this is a documented restriction.
- Exactly one transaction is outstanding at a time. Non-granted masters see ready=0 and rsp_valid=0 throughout.
- NUM_REQ=1 degenerates to a pass-through plus the 1-cycle grant latency and the timeout.

Decomposition:
- csr_arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_FAULT} csr_arb_state_e.
  - CSR_ARB_FAULT_RDATA = '0.
- Sub-module csr_rr_pick:
  - Combinational rotate-priority picker.
  - Inputs: req vector, ptr. Outputs: any, idx.
  - Reused by other arbiters.

Test Plan:
- Single master 1 write addr 0x10 wdata 0xA5A5_0000 → s_req_valid rises 1 cycle after m_req_valid. Slave responds 2 cycles after accept with rdata 0 → m_rsp_valid[1] only, rr_ptr=2.
- Masters 0,1,2 hold requests continuously; slave is zero-latency (same-cycle rsp) → grants are 0,1,2,0,… with no starvation; each transaction takes 2 cycles.
- TIMEOUT_CYC=4, slave never responds → m_rsp_valid[g] with fault=1, rdata=0 on the 5th cycle after accept. timeout_pulse is high for 1 cycle, then the next master is granted.
- s_rsp_valid asserted while IDLE → s_rsp_ready=1, stale_drop_pulse=1, no m_rsp_valid.
- Backpressure: s_req_ready=0 for 3 cycles, then m_rsp_ready[g]=0 for 2 cycles → s_req_* and m_rsp_* are stable throughout, and other masters are not granted.
- rst_n asserted mid-WAIT → all outputs 0 immediately (async), state IDLE, rr_ptr=0; master 0 wins the first arbitration after release.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// Shared types and helpers for the CSR arbiter and its round-robin picker.
package csr_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_FAULT
   } csr_arb_state_e;

   // Single fill bit; replicated to DATA_W wherever a synthesized fault drives read data.
   localparam logic CSR_ARB_FAULT_RDATA = 1'b0;

   // Round-robin successor of idx among n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/csr_rr_pick.sv
// Combinational rotate-priority picker: first set request at ptr, ptr+1, ... mod N.
module csr_rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      int cand;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr) + off) % N;
         if (!any && req[cand[IDX_W-1:0]]) begin
            any = 1'b1;
            idx = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/csr_arb.sv
// Round-robin arbiter sharing one CSR slave channel among NUM_REQ masters, one
// transaction in flight, with a response timeout that synthesizes a fault reply.
module csr_arb
   import csr_arb_pkg::*;
#(
   parameter int  NUM_REQ     = 3,
   parameter int  ADDR_W      = 32,
   parameter int  DATA_W      = 32,
   parameter int  PRIV_W      = 2,
   parameter int  TIMEOUT_CYC = 64,
   localparam int STRB_W      = DATA_W / 8,
   localparam int IDX_W       = $clog2((NUM_REQ > 2) ? NUM_REQ : 2)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          m_req_valid,
   output logic [NUM_REQ-1:0]          m_req_ready,
   input  logic [NUM_REQ-1:0]          m_req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   m_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   m_req_wdata,
   input  logic [NUM_REQ*STRB_W-1:0]   m_req_wstrb,
   input  logic [NUM_REQ*PRIV_W-1:0]   m_req_priv,
   output logic [NUM_REQ-1:0]          m_rsp_valid,
   input  logic [NUM_REQ-1:0]          m_rsp_ready,
   output logic [DATA_W-1:0]           m_rsp_rdata,
   output logic                        m_rsp_fault,
   output logic                        m_rsp_side_effect,
   output logic                        s_req_valid,
   input  logic                        s_req_ready,
   output logic                        s_req_write,
   output logic [ADDR_W-1:0]           s_req_addr,
   output logic [DATA_W-1:0]           s_req_wdata,
   output logic [STRB_W-1:0]           s_req_wstrb,
   output logic [PRIV_W-1:0]           s_req_priv,
   input  logic                        s_rsp_valid,
   output logic                        s_rsp_ready,
   input  logic [DATA_W-1:0]           s_rsp_rdata,
   input  logic                        s_rsp_fault,
   input  logic                        s_rsp_side_effect,
   output logic                        busy,
   output logic [IDX_W-1:0]            grant_id,
   output logic                        timeout_pulse,
   output logic                        stale_drop_pulse
);

   localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   logic [ADDR_W-1:0] req_addr  [NUM_REQ];
   logic [DATA_W-1:0] req_wdata [NUM_REQ];
   logic [STRB_W-1:0] req_wstrb [NUM_REQ];
   logic [PRIV_W-1:0] req_priv  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_addr[i]  = m_req_addr[i*ADDR_W +: ADDR_W];
      assign req_wdata[i] = m_req_wdata[i*DATA_W +: DATA_W];
      assign req_wstrb[i] = m_req_wstrb[i*STRB_W +: STRB_W];
      assign req_priv[i]  = m_req_priv[i*PRIV_W +: PRIV_W];
   end

   csr_arb_state_e   state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tpulse_q, tpulse_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             req_valid_g;
   logic             rsp_ready_g;
   logic [IDX_W-1:0] ptr_after_g;
   logic             route_rsp;
   logic             stale_ok;

   csr_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (m_req_valid),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign req_valid_g = m_req_valid[grant_q];
   assign rsp_ready_g = m_rsp_ready[grant_q];
   assign ptr_after_g = IDX_W'(rr_next(int'(grant_q), NUM_REQ));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         tpulse_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         tpulse_q <= tpulse_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      ptr_d             = ptr_q;
      cnt_d             = cnt_q;
      tpulse_d          = 1'b0;
      route_rsp         = 1'b0;
      stale_ok          = 1'b0;
      m_req_ready       = '0;
      m_rsp_valid       = '0;
      m_rsp_rdata       = '0;
      m_rsp_fault       = 1'b0;
      m_rsp_side_effect = 1'b0;
      s_req_valid       = 1'b0;
      s_req_write       = 1'b0;
      s_req_addr        = '0;
      s_req_wdata       = '0;
      s_req_wstrb       = '0;
      s_req_priv        = '0;
      s_rsp_ready       = 1'b0;
      stale_drop_pulse  = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            stale_ok = 1'b1;
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = ARB_ISSUE;
            end
         end

         ARB_ISSUE: begin
            s_req_valid          = req_valid_g;
            s_req_write          = m_req_write[grant_q];
            s_req_addr           = req_addr[grant_q];
            s_req_wdata          = req_wdata[grant_q];
            s_req_wstrb          = req_wstrb[grant_q];
            s_req_priv           = req_priv[grant_q];
            m_req_ready[grant_q] = s_req_ready;
            if (!req_valid_g) begin
               // Master withdrew its request: abandon the grant without advancing fairness.
               stale_ok = 1'b1;
               state_d  = ARB_IDLE;
            end else if (s_req_ready) begin
               route_rsp = 1'b1;
               if (s_rsp_valid && rsp_ready_g) begin
                  state_d = ARB_IDLE;
                  ptr_d   = ptr_after_g;
               end else begin
                  state_d = ARB_WAIT;
                  cnt_d   = '0;
               end
            end else begin
               stale_ok = 1'b1;
            end
         end

         ARB_WAIT: begin
            route_rsp = 1'b1;
            if (s_rsp_valid) begin
               // A response in the terminal count cycle still wins over the timeout.
               if (rsp_ready_g) begin
                  state_d = ARB_IDLE;
                  ptr_d   = ptr_after_g;
               end
            end else if (TIMEOUT_CYC != 0) begin
               if (cnt_q == CNT_W'(CNT_MAX)) begin
                  state_d  = ARB_FAULT;
                  tpulse_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ARB_FAULT: begin
            m_rsp_valid[grant_q] = 1'b1;
            m_rsp_rdata          = {DATA_W{CSR_ARB_FAULT_RDATA}};
            m_rsp_fault          = 1'b1;
            if (rsp_ready_g) begin
               state_d = ARB_IDLE;
               ptr_d   = ptr_after_g;
            end
         end
      endcase

      if (route_rsp) begin
         m_rsp_valid[grant_q] = s_rsp_valid;
         m_rsp_rdata          = s_rsp_rdata;
         m_rsp_fault          = s_rsp_fault;
         m_rsp_side_effect    = s_rsp_side_effect;
         s_rsp_ready          = rsp_ready_g;
      end

      // Unsolicited responses are swallowed, except while reset holds every ready low.
      if (stale_ok && rst_n && s_rsp_valid) begin
         s_rsp_ready      = 1'b1;
         stale_drop_pulse = 1'b1;
      end
   end

   assign busy          = (state_q != ARB_IDLE);
   assign grant_id      = grant_q;
   assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_csr_arb.sv
// Randomized bench for csr_arb: bench-driven masters and slave, checked against a
// transaction-level round-robin / timeout model, plus directed reset scenarios.
module tb_csr_arb;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int PW = 2;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    m_req_valid, m_req_ready, m_req_write;
   logic [N*AW-1:0] m_req_addr;
   logic [N*DW-1:0] m_req_wdata;
   logic [N*SW-1:0] m_req_wstrb;
   logic [N*PW-1:0] m_req_priv;
   logic [N-1:0]    m_rsp_valid, m_rsp_ready;
   logic [DW-1:0]   m_rsp_rdata;
   logic            m_rsp_fault, m_rsp_side_effect;
   logic            s_req_valid, s_req_ready, s_req_write;
   logic [AW-1:0]   s_req_addr;
   logic [DW-1:0]   s_req_wdata;
   logic [SW-1:0]   s_req_wstrb;
   logic [PW-1:0]   s_req_priv;
   logic            s_rsp_valid, s_rsp_ready;
   logic [DW-1:0]   s_rsp_rdata;
   logic            s_rsp_fault, s_rsp_side_effect;
   logic            busy;
   logic [1:0]      grant_id;
   logic            timeout_pulse, stale_drop_pulse;

   logic [AW-1:0]   b_addr  [N];
   logic [DW-1:0]   b_wdata [N];
   logic [SW-1:0]   b_wstrb [N];
   logic [PW-1:0]   b_priv  [N];

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign m_req_addr[i*AW +: AW]  = b_addr[i];
      assign m_req_wdata[i*DW +: DW] = b_wdata[i];
      assign m_req_wstrb[i*SW +: SW] = b_wstrb[i];
      assign m_req_priv[i*PW +: PW]  = b_priv[i];
   end

   csr_arb #(
      .NUM_REQ     (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .PRIV_W      (PW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .m_req_valid       (m_req_valid),
      .m_req_ready       (m_req_ready),
      .m_req_write       (m_req_write),
      .m_req_addr        (m_req_addr),
      .m_req_wdata       (m_req_wdata),
      .m_req_wstrb       (m_req_wstrb),
      .m_req_priv        (m_req_priv),
      .m_rsp_valid       (m_rsp_valid),
      .m_rsp_ready       (m_rsp_ready),
      .m_rsp_rdata       (m_rsp_rdata),
      .m_rsp_fault       (m_rsp_fault),
      .m_rsp_side_effect (m_rsp_side_effect),
      .s_req_valid       (s_req_valid),
      .s_req_ready       (s_req_ready),
      .s_req_write       (s_req_write),
      .s_req_addr        (s_req_addr),
      .s_req_wdata       (s_req_wdata),
      .s_req_wstrb       (s_req_wstrb),
      .s_req_priv        (s_req_priv),
      .s_rsp_valid       (s_rsp_valid),
      .s_rsp_ready       (s_rsp_ready),
      .s_rsp_rdata       (s_rsp_rdata),
      .s_rsp_fault       (s_rsp_fault),
      .s_rsp_side_effect (s_rsp_side_effect),
      .busy              (busy),
      .grant_id          (grant_id),
      .timeout_pulse     (timeout_pulse),
      .stale_drop_pulse  (stale_drop_pulse)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference model state: who owns the channel and where its transaction stands.
   logic [N-1:0] pend;
   int           owner = -1;
   logic [1:0]   og;
   bit           accepted;
   bit           silent;
   int           lat;
   int           since_acc;
   int           exp_ptr = 0;

   function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (ptr + k) % N;
         if (req[2'(j)]) return j;
      end
      return -1;
   endfunction

   task automatic step(input bit gen);
      logic [N-1:0] oh;
      bit           done;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (gen && !pend[2'(i)] && $urandom_range(0, 3) == 0) begin
            pend[2'(i)]        = 1'b1;
            m_req_write[2'(i)] = ($urandom_range(0, 1) == 1);
            b_addr[i]          = $urandom;
            b_wdata[i]         = $urandom;
            b_wstrb[i]         = 4'($urandom);
            b_priv[i]          = 2'($urandom);
         end
         m_rsp_ready[2'(i)] = ($urandom_range(0, 3) != 0);
      end
      m_req_valid       = pend;
      s_req_ready       = 1'b0;
      s_rsp_valid       = 1'b0;
      s_rsp_rdata       = $urandom;
      s_rsp_fault       = ($urandom_range(0, 1) == 1);
      s_rsp_side_effect = ($urandom_range(0, 1) == 1);
      if (owner < 0) begin
         s_req_ready = ($urandom_range(0, 1) == 1);
         s_rsp_valid = ($urandom_range(0, 9) == 0);
      end else if (!accepted) begin
         s_req_ready = ($urandom_range(0, 1) == 1);
         if (s_req_ready) begin
            silent    = ($urandom_range(0, 5) == 0);
            lat       = int'($urandom_range(0, TO));
            since_acc = 0;
         end else begin
            s_rsp_valid = ($urandom_range(0, 6) == 0);
         end
      end else begin
         since_acc++;
      end
      if (owner >= 0 && (accepted || s_req_ready) && !silent && since_acc >= lat) begin
         s_rsp_valid       = 1'b1;
         s_rsp_rdata       = rsp_data(b_addr[og]);
         s_rsp_fault       = b_addr[og][2];
         s_rsp_side_effect = b_addr[og][3];
      end

      #1;
      oh   = 3'b001 << og;
      done = 1'b0;
      if (owner < 0) begin
         check("idle_busy", 64'(busy), 64'd0);
         check("idle_sreq_valid", 64'(s_req_valid), 64'd0);
         check("idle_mreq_ready", 64'(m_req_ready), 64'd0);
         check("idle_mrsp_valid", 64'(m_rsp_valid), 64'd0);
         check("idle_srsp_ready", 64'(s_rsp_ready), 64'(s_rsp_valid));
         check("idle_stale", 64'(stale_drop_pulse), 64'(s_rsp_valid));
         check("idle_tpulse", 64'(timeout_pulse), 64'd0);
         if (|m_req_valid) begin
            owner    = rr_pick(m_req_valid, exp_ptr);
            og       = 2'(owner);
            accepted = 1'b0;
         end
      end else begin
         check("own_busy", 64'(busy), 64'd1);
         check("own_grant", 64'(grant_id), 64'(og));
         if (!accepted) begin
            check("iss_sreq_valid", 64'(s_req_valid), 64'd1);
            check("iss_addr", 64'(s_req_addr), 64'(b_addr[og]));
            check("iss_wdata", 64'(s_req_wdata), 64'(b_wdata[og]));
            check("iss_wstrb", 64'(s_req_wstrb), 64'(b_wstrb[og]));
            check("iss_priv", 64'(s_req_priv), 64'(b_priv[og]));
            check("iss_write", 64'(s_req_write), 64'(m_req_write[og]));
            check("iss_mreq_ready", 64'(m_req_ready), 64'(s_req_ready ? oh : 3'b000));
         end else begin
            check("wait_sreq_valid", 64'(s_req_valid), 64'd0);
            check("wait_mreq_ready", 64'(m_req_ready), 64'd0);
         end
         if (!accepted && !s_req_ready) begin
            check("pre_mrsp_valid", 64'(m_rsp_valid), 64'd0);
            check("pre_srsp_ready", 64'(s_rsp_ready), 64'(s_rsp_valid));
            check("pre_stale", 64'(stale_drop_pulse), 64'(s_rsp_valid));
         end else begin
            if (!accepted) pend[og] = 1'b0;
            accepted = 1'b1;
            check("rsp_stale", 64'(stale_drop_pulse), 64'd0);
            if (silent && since_acc >= TO + 1) begin
               check("flt_mrsp_valid", 64'(m_rsp_valid), 64'(oh));
               check("flt_rdata", 64'(m_rsp_rdata), 64'd0);
               check("flt_fault", 64'(m_rsp_fault), 64'd1);
               check("flt_side", 64'(m_rsp_side_effect), 64'd0);
               check("flt_srsp_ready", 64'(s_rsp_ready), 64'd0);
               check("flt_tpulse", 64'(timeout_pulse), 64'(since_acc == TO + 1));
               done = m_rsp_ready[og];
            end else begin
               check("rsp_mrsp_valid", 64'(m_rsp_valid), 64'(s_rsp_valid ? oh : 3'b000));
               check("rsp_srsp_ready", 64'(s_rsp_ready), 64'(m_rsp_ready[og]));
               check("rsp_tpulse", 64'(timeout_pulse), 64'd0);
               if (s_rsp_valid) begin
                  check("rsp_rdata", 64'(m_rsp_rdata), 64'(rsp_data(b_addr[og])));
                  check("rsp_fault", 64'(m_rsp_fault), 64'(b_addr[og][2]));
                  check("rsp_side", 64'(m_rsp_side_effect), 64'(b_addr[og][3]));
               end
               done = s_rsp_valid && m_rsp_ready[og];
            end
         end
         if (done) begin
            exp_ptr = (owner + 1) % N;
            owner   = -1;
         end
      end
   endtask

   initial begin
      pend              = '0;
      m_req_valid       = '0;
      m_req_write       = '0;
      m_rsp_ready       = '0;
      s_req_ready       = 1'b0;
      s_rsp_valid       = 1'b0;
      s_rsp_rdata       = '0;
      s_rsp_fault       = 1'b0;
      s_rsp_side_effect = 1'b0;
      og                = '0;
      for (int i = 0; i < N; i++) begin
         b_addr[i]  = '0;
         b_wdata[i] = '0;
         b_wstrb[i] = '0;
         b_priv[i]  = '0;
      end

      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_grant", 64'(grant_id), 64'd0);
      check("rst_sreq_valid", 64'(s_req_valid), 64'd0);
      check("rst_mreq_ready", 64'(m_req_ready), 64'd0);
      check("rst_mrsp_valid", 64'(m_rsp_valid), 64'd0);
      check("rst_srsp_ready", 64'(s_rsp_ready), 64'd0);
      check("rst_pulses", 64'({timeout_pulse, stale_drop_pulse}), 64'd0);
      rst_n = 1'b1;

      for (int c = 0; c < 4000; c++) step(1'b1);
      for (int c = 0; c < 300; c++) step(1'b0);
      check("drain_busy", 64'(busy), 64'd0);

      // Directed: master 1 write, slave answers two cycles after acceptance.
      @(negedge clk);
      m_req_valid    = 3'b010;
      m_req_write    = 3'b010;
      b_addr[1]      = 32'h0000_0010;
      b_wdata[1]     = 32'hA5A5_0000;
      s_req_ready    = 1'b1;
      s_rsp_valid    = 1'b0;
      m_rsp_ready    = '0;
      #1 check("dir_grant_latency", 64'(s_req_valid), 64'd0);
      @(negedge clk);
      #1 check("dir_sreq_valid", 64'(s_req_valid), 64'd1);
      check("dir_sreq_addr", 64'(s_req_addr), 64'h10);
      check("dir_sreq_wdata", 64'(s_req_wdata), 64'hA5A5_0000);
      @(negedge clk);
      m_req_valid = '0;
      s_req_ready = 1'b0;
      #1 check("dir_wait_rsp", 64'(m_rsp_valid), 64'd0);
      @(negedge clk);
      s_rsp_valid = 1'b1;
      s_rsp_rdata = '0;
      s_rsp_fault = 1'b0;
      s_rsp_side_effect = 1'b0;
      m_rsp_ready = 3'b010;
      #1 check("dir_mrsp_valid", 64'(m_rsp_valid), 64'b010);
      check("dir_mrsp_rdata", 64'(m_rsp_rdata), 64'd0);
      check("dir_srsp_ready", 64'(s_rsp_ready), 64'd1);
      @(negedge clk);
      s_rsp_valid = 1'b0;
      m_rsp_ready = '0;
      #1 check("dir_done_idle", 64'(busy), 64'd0);

      // Directed: master 2 accepted, then reset lands mid-WAIT.
      @(negedge clk);
      m_req_valid = 3'b100;
      b_addr[2]   = 32'h0000_0020;
      s_req_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_req_valid = '0;
      s_req_ready = 1'b0;
      #1 check("dir_wait_busy", 64'(busy), 64'd1);
      check("dir_wait_grant", 64'(grant_id), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_grant", 64'(grant_id), 64'd0);
      check("arst_ready_valid", 64'({m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready}), 64'd0);
      check("arst_pulses", 64'({timeout_pulse, stale_drop_pulse}), 64'd0);
      check("arst_sreq_addr", 64'(s_req_addr), 64'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      m_req_valid = 3'b111;
      @(negedge clk);
      #1 check("post_rst_winner", 64'(grant_id), 64'd0);
      check("post_rst_addr", 64'(s_req_addr), 64'(b_addr[0]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
